cordic_vectoring: RTL and testbench
===================================

# cordic_vectoring

Iterative vectoring-mode CORDIC, the inverse of the existing rotation-mode `cordic` core. It accepts a Cartesian vector (x, y) and returns its polar form: a binary angle `out_angle` = atan2(y, x) and a gain-compensated magnitude `out_mag` = sqrt(x²+y²). The core uses the same start/done level handshake and the same 32-bit binary-angle format as the rotation core, so the two can be chained, for example for rotate-then-recover checks.

## Interface
- `WIDTH`, 32: width of the x/y inputs, the angle output and the magnitude output.
- `ITERATIONS`, 30: number of micro-rotations; must be ≤ `WIDTH`-2.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level request, sampled only in IDLE.
- `x_in`  in  `WIDTH`: signed two's-complement x.
- `y_in`  in  `WIDTH`: signed two's-complement y.
- `done`  out  1: high while the result is valid (DONE state).
- `out_angle`  out  `WIDTH`: binary angle, 2^`WIDTH` = 2π, so 0x4000_0000 = π/2 and 0x8000_0000 = −π.
- `out_mag`  out  `WIDTH`: unsigned magnitude, same scale as the inputs.

## Operation
- **States:**
  - IDLE: waits for `start`.
  - ITER: runs the micro-rotations.
  - COMP: applies gain compensation.
  - DONE: holds the result.
- **IDLE → ITER** on a clock edge with `start`=1. On that edge the core captures the inputs with pre-rotation:
  - If `x_in` < 0: internal x = −`x_in`, y = −`y_in`, z = 0x8000_0000.
  - Otherwise: x = `x_in`, y = `y_in`, z = 0.
- **Internal widths:**
  - x and y are signed `WIDTH`+2 bits, sign-extended. This covers −(−2^31) and the CORDIC gain K≈1.6468 with no overflow.
  - z is `WIDTH` bits and wraps modulo 2^`WIDTH`.
- **Micro-rotation i** (i = 0..`ITERATIONS`-1), one per cycle in ITER:
  - If y ≥ 0: x += y>>>i, y −= x>>>i, z += ATAN[i].
  - Else: x −= y>>>i, y += x>>>i, z −= ATAN[i].
  - All three updates use the old values. Shifts are arithmetic.
- **ITER → COMP** after iteration `ITERATIONS`-1 completes.
- **COMP:**
  - out_mag = (x × INV_GAIN) >> 32, truncated to `WIDTH` unsigned bits.
  - out_angle = z.
  - Go to DONE.
- **DONE:**
  - `done`=1; outputs are held.
  - DONE → IDLE on the first edge with `start`=0.
  - While `start` stays 1, the core remains in DONE and does not restart.
- **Zero vector:** if `x_in`=`y_in`=0 at capture, a flag forces out_angle=0 and out_mag=0 in COMP. Latency is unchanged.
- `start` is ignored in ITER and COMP. Input changes after the capture edge have no effect.
- **Output stability:** `out_angle` and `out_mag` change only on the COMP→DONE edge and otherwise hold the last result.
- **Accuracy:** for `ITERATIONS`=30, `WIDTH`=32:
  - |angle error| ≤ 64 LSB.
  - |mag error| ≤ 16 LSB, plus 2^-20 relative.

## Timing
- **Reset values:** asserting `reset_n`=0 at any time (including mid-ITER) immediately sets state=IDLE, `done`=0, `out_angle`=0, `out_mag`=0, and clears the iteration counter.
- **Latency:** capture edge = edge 0. ITER occupies edges 1..`ITERATIONS`, COMP is edge `ITERATIONS`+1, and `done` rises after that edge. Default: `done` is high 31 cycles after the capture edge.
- **Back-to-back:** `done` falls one edge after `start` falls. A new capture needs `start`=1 while in IDLE, so the minimum issue interval is `ITERATIONS`+3 cycles.

## Structure
- **Package `cordic_pkg`**, shared with the rotation core:
  - `ATAN_TABLE[0..WIDTH-1]` = round(atan(2^-i)·2^32/2π), starting 0x2000_0000, 0x12E4_051E, 0x09FB_385B, 0x0511_11D4, 0x028B_0D43.
  - `INV_GAIN` = 0x9B74_EDA8 (1/K in unsigned Q0.32).
  - The state enum.
- **Sub-module `cordic_microrot`:** one combinational micro-rotation with a direction input, shift amount and table entry. The rotation core reuses it.
- The iteration counter and the multiply in COMP live in the top module.

## Test plan
1. x=0x4000_0000, y=0 → after 31 cycles `done`=1, out_angle=0 ±64, out_mag=0x4000_0000 ±16.
2. x=0, y=0x4000_0000 → out_angle=0x4000_0000 ±64, out_mag=0x4000_0000 ±16.
3. x=y=0x4000_0000 → angle 0x2000_0000 ±64, mag 0x5A82_7999 ±16. Then x=y=−0x4000_0000 → angle 0xA000_0000 ±64, same mag.
4. x=0x8000_0000, y=0 → angle 0x8000_0000 ±64, mag 0x8000_0000 ±16. Then x=y=0 → angle 0, mag 0 exactly.
5. Handshake:
   - Hold `start`=1 through DONE → `done` stays 1 for 10 cycles and outputs are stable.
   - Drop `start` → `done`=0 on the next edge.
   - Toggle `start` and the inputs during ITER → result is unchanged.
6. Pull `reset_n` low at iteration 12, between edges → `done`, `out_angle`, `out_mag` read 0 before the next edge. After release, a fresh request (case 1) completes in 31 cycles.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// cordic_pkg : shared constants for the rotation and vectoring CORDIC cores
// Rev 1.0
// ============================================================================
package cordic_pkg;

    // round(atan(2^-i) * 2^32 / 2pi), binary angle where 2^32 == 2pi
    localparam logic [31:0] ATAN_TABLE [0:31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // 1/K in unsigned Q0.32
    localparam logic [31:0] INV_GAIN = 32'h9B74_EDA8;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ITER = 2'd1;
    localparam state_t S_COMP = 2'd2;
    localparam state_t S_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_if.sv
`default_nettype none
// ============================================================================
// cordic_vectoring_if : start/done request bus with Cartesian in, polar out
// Rev 1.0
// ============================================================================
interface cordic_vectoring_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             done;
    logic [WIDTH-1:0] out_angle;
    logic [WIDTH-1:0] out_mag;

    modport master (output start, x_in, y_in, input  done, out_angle, out_mag);
    modport slave  (input  start, x_in, y_in, output done, out_angle, out_mag);
endinterface
`default_nettype wire

// File: rtl/cordic_microrot.sv
`default_nettype none
// ============================================================================
// cordic_microrot : one combinational CORDIC micro-rotation step
// Rev 1.0
// ============================================================================
module cordic_microrot #(
    parameter int XW = 34,
    parameter int ZW = 32,
    parameter int SW = 5
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic        [ZW-1:0] z_i,
    input  logic                 neg_i,
    input  logic        [SW-1:0] shift_i,
    input  logic        [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic        [ZW-1:0] z_o
);
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;

    assign w_xs = x_i >>> shift_i;
    assign w_ys = y_i >>> shift_i;

    // neg_i selects the clockwise-vs-counterclockwise step
    always_comb begin
        if (neg_i) begin
            x_o = x_i - w_ys;
            y_o = y_i + w_xs;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + w_ys;
            y_o = y_i - w_xs;
            z_o = z_i + atan_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
// cordic_vectoring : iterative vectoring CORDIC, (x, y) -> (atan2, magnitude)
// Rev 1.0
// ============================================================================
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    cordic_vectoring_if.slave  bus
);
    localparam int XW = WIDTH + 2;
    localparam int SW = $clog2(WIDTH);
    localparam int PW = XW + 32;
    localparam logic [WIDTH-1:0] Z_PI = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [SW-1:0]        iter_q, iter_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]     z_q, z_d;
    logic [WIDTH-1:0]     angle_q, angle_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic                 zero_q, zero_d;

    logic signed [XW-1:0] w_xin, w_yin, w_xr, w_yr;
    logic [WIDTH-1:0]     w_zr, w_atan, w_mag;
    logic [PW-1:0]        w_prod;

    assign w_xin  = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
    assign w_yin  = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
    assign w_atan = WIDTH'(ATAN_TABLE[iter_q] >> (32 - WIDTH));
    // x is non-negative after pre-rotation, so the unsigned product is exact
    assign w_prod = PW'($unsigned(x_q)) * PW'(INV_GAIN);
    assign w_mag  = WIDTH'(w_prod >> 32);

    cordic_microrot #(
        .XW (XW),
        .ZW (WIDTH),
        .SW (SW)
    ) u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .neg_i   (y_q[XW-1]),
        .shift_i (iter_q),
        .atan_i  (w_atan),
        .x_o     (w_xr),
        .y_o     (w_yr),
        .z_o     (w_zr)
    );

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // fold the left half-plane onto the right by a pi rotation
                    if (bus.x_in[WIDTH-1]) begin
                        x_d = -w_xin;
                        y_d = -w_yin;
                        z_d = Z_PI;
                    end else begin
                        x_d = w_xin;
                        y_d = w_yin;
                        z_d = '0;
                    end
                    zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
                    iter_d  = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                x_d = w_xr;
                y_d = w_yr;
                z_d = w_zr;
                if (iter_q == SW'(ITERATIONS - 1)) begin
                    state_d = S_COMP;
                end else begin
                    iter_d = iter_q + SW'(1);
                end
            end
            S_COMP: begin
                angle_d = zero_q ? '0 : z_q;
                mag_d   = zero_q ? '0 : w_mag;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            angle_q <= '0;
            mag_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.done      = (state_q == S_DONE);
    assign bus.out_angle = angle_q;
    assign bus.out_mag   = mag_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
// tb_cordic_vectoring : randomized and directed checks against a real-math model
// Rev 1.0
// ============================================================================
module tb_cordic_vectoring;
    localparam int  WIDTH      = 32;
    localparam int  ITERATIONS = 30;
    localparam int  LATENCY    = ITERATIONS + 1;
    localparam real PI         = 3.14159265358979323846;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    cordic_vectoring_if #(.WIDTH(WIDTH)) bus ();

    cordic_vectoring #(
        .WIDTH      (WIDTH),
        .ITERATIONS (ITERATIONS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp,
                       input longint tol, input bit wrap);
        longint     d;
        logic [31:0] dw;
        n_chk++;
        if (wrap) begin
            dw = 32'(obs - exp);
            d  = longint'($signed(dw));
        end else begin
            d = obs - exp;
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    // polar form from plain real arithmetic
    task automatic ref_polar(input logic [31:0] x, input logic [31:0] y,
                             output longint ang, output longint mag, output longint mtol);
        real xr, yr, a, r;
        longint la;
        xr = $itor($signed(x));
        yr = $itor($signed(y));
        if (x == 0 && y == 0) begin
            ang = 0; mag = 0; mtol = 0;
        end else begin
            a    = $atan2(yr, xr);
            la   = longint'(a / (2.0 * PI) * 4294967296.0);
            ang  = la & 64'hFFFF_FFFF;
            r    = $sqrt(xr * xr + yr * yr);
            mag  = longint'(r);
            mtol = 16 + longint'(r / 1048576.0);
        end
    endtask

    task automatic run_case(input logic [31:0] x, input logic [31:0] y,
                            input bit drop, input bit scramble);
        longint ea, em, mt, at;
        int n;
        ref_polar(x, y, ea, em, mt);
        at = (mt == 0) ? 0 : 64;
        bus.x_in  = x;
        bus.y_in  = y;
        bus.start = 1'b1;
        tick;
        n = 0;
        while (!bus.done && n < 40) begin
            if (scramble) begin
                if (n < 20) begin
                    bus.start = 1'($urandom_range(0, 1));
                    bus.x_in  = $urandom();
                    bus.y_in  = $urandom();
                end else begin
                    bus.start = 1'b1;
                end
            end
            tick;
            n++;
        end
        chk("latency", n, LATENCY, 0, 1'b0);
        chk("angle", longint'(bus.out_angle), ea, at, 1'b1);
        chk("mag", longint'(bus.out_mag), em, mt, 1'b0);
        if (drop) begin
            bus.start = 1'b0;
            tick;
            chk("done_fall", longint'(bus.done), 0, 0, 1'b0);
        end
    endtask

    initial begin
        longint ea, em, mt;
        n_chk     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        #1;
        chk("rst_done", longint'(bus.done), 0, 0, 1'b0);
        chk("rst_angle", longint'(bus.out_angle), 0, 0, 1'b0);
        chk("rst_mag", longint'(bus.out_mag), 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick;

        run_case(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_case(32'h0000_0000, 32'h4000_0000, 1'b1, 1'b0);
        run_case(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0);
        run_case(32'hC000_0000, 32'hC000_0000, 1'b1, 1'b0);
        run_case(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_case(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_case(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);

        // start held through DONE: no restart, outputs stable
        run_case(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        ref_polar(32'h4000_0000, 32'h4000_0000, ea, em, mt);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("hold_done", longint'(bus.done), 1, 0, 1'b0);
            chk("hold_angle", longint'(bus.out_angle), ea, 64, 1'b1);
            chk("hold_mag", longint'(bus.out_mag), em, mt, 1'b0);
        end
        bus.start = 1'b0;
        tick;
        chk("drop_done", longint'(bus.done), 0, 0, 1'b0);
        chk("idle_angle", longint'(bus.out_angle), ea, 64, 1'b1);

        // start and inputs thrash during ITER
        run_case(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
        run_case(32'h9000_1234, 32'h2345_6789, 1'b1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_case($urandom(), $urandom(), 1'b1, 1'b0);
        end

        // asynchronous reset in the middle of ITER
        run_case(32'h3000_0000, 32'hE000_0000, 1'b1, 1'b0);
        bus.x_in  = 32'h4000_0000;
        bus.y_in  = 32'h0000_0000;
        bus.start = 1'b1;
        tick;
        repeat (12) tick;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_done", longint'(bus.done), 0, 0, 1'b0);
        chk("arst_angle", longint'(bus.out_angle), 0, 0, 1'b0);
        chk("arst_mag", longint'(bus.out_mag), 0, 0, 1'b0);
        #1 reset_n = 1'b1;
        bus.start = 1'b0;
        tick;
        chk("arst_idle", longint'(bus.done), 0, 0, 1'b0);
        run_case(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
